sample_scheduler: RTL and testbench

SAMPLE_SCHEDULER -- requirements
Module: sample_scheduler

---
 rtl/sample_scheduler_if.sv | 33 +++
 rtl/sample_scheduler.sv | 139 +++++++++++++
 tb/tb_sample_scheduler.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sample_scheduler_if.sv
// sample_scheduler_if
//   Groups the sample-input strobes and the stereo-pair output handshake of
//   sample_scheduler into one bundle.
//   Ports (signals):
//     vin, din[W], in_channel    decoded sample strobe, data and channel (0=L, 1=R)
//     kill                       upstream framing-error abort strobe
//     channelvout                channel-status block complete (lock evidence)
//     conv_ready                 downstream engine accepts a pair
//     conv_valid, conv_left/right  presented stereo pair
//   Modports: master = upstream/downstream environment, slave = scheduler.
interface sample_scheduler_if #(
  parameter int W = 20
);
  logic         vin;
  logic [W-1:0] din;
  logic         in_channel;
  logic         kill;
  logic         channelvout;
  logic         conv_ready;
  logic         conv_valid;
  logic [W-1:0] conv_left;
  logic [W-1:0] conv_right;

  modport master (
    output vin, din, in_channel, kill, channelvout, conv_ready,
    input  conv_valid, conv_left, conv_right
  );

  modport slave (
    input  vin, din, in_channel, kill, channelvout, conv_ready,
    output conv_valid, conv_left, conv_right
  );
endinterface

// File: rtl/sample_scheduler.sv
// sample_scheduler
//   Pairs decoded left/right audio samples into stereo pairs once the upstream
//   decoder has shown lock (a completed channel-status block), and queues the
//   pairs in a DEPTH-entry FIFO for a downstream convolution engine.
//   Ports:
//     clk            audio-domain clock
//     rst            asynchronous, active-high reset
//     bus            sample_scheduler_if.slave (sample input + pair output)
//     locked         high while pairing samples (WAIT_LEFT / WAIT_RIGHT)
//     fill           number of pairs currently stored (0..DEPTH)
//     overrun_count  pairs dropped on a full FIFO, saturating at 255
module sample_scheduler #(
  parameter int DEPTH = 8,
  parameter int W     = 20
) (
  input  logic                     clk,
  input  logic                     rst,
  sample_scheduler_if.slave        bus,
  output logic                     locked,
  output logic [$clog2(DEPTH):0]   fill,
  output logic [7:0]               overrun_count
);

  localparam int             AW      = $clog2(DEPTH);
  localparam logic [AW:0]    DEPTH_F = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    UNLOCKED,
    WAIT_LEFT,
    WAIT_RIGHT
  } state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   held_q, held_d;
  logic           push_req;

  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic [2*W-1:0] mem [DEPTH];
  logic [2*W-1:0] rd_data;
  logic           pop;
  logic           push_ok;

  // ---------------------------------------------------------------------------
  // Pairing FSM: next state and push request
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of this block is given a default first so no path
    // leaves a variable unassigned, which would otherwise infer a latch.
    state_d  = state_q;
    held_d   = held_q;
    push_req = 1'b0;

    if (bus.kill) begin
      // Abort wins over everything else in the same cycle.
      state_d = UNLOCKED;
      held_d  = '0;
    end else begin
      case (state_q)
        UNLOCKED: begin
          if (bus.channelvout) state_d = WAIT_LEFT;
        end
        WAIT_LEFT: begin
          // A right sample here has no partner; dropping it keeps L/R aligned.
          if (bus.vin && !bus.in_channel) begin
            held_d  = bus.din;
            state_d = WAIT_RIGHT;
          end
        end
        WAIT_RIGHT: begin
          if (bus.vin) begin
            if (bus.in_channel) begin
              push_req = 1'b1;
              state_d  = WAIT_LEFT;
            end else begin
              // A newer left sample replaces the stale one.
              held_d = bus.din;
            end
          end
        end
        default: state_d = UNLOCKED;
      endcase
    end
  end

  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= UNLOCKED;
      held_q  <= '0;
    end else begin
      state_q <= state_d;
      held_q  <= held_d;
    end
  end

  assign locked = (state_q != UNLOCKED);

  // ---------------------------------------------------------------------------
  // Pair FIFO
  // ---------------------------------------------------------------------------
  assign bus.conv_valid = (fill != '0);
  assign pop            = bus.conv_valid & bus.conv_ready;
  // A full FIFO still accepts a pair when a slot is freed on the same edge.
  assign push_ok        = push_req & ((fill < DEPTH_F) | pop);

  // NOTE: the storage array has no reset; stale entries are never visible
  // because the outputs below are forced to zero whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= {held_q, bus.din};
  end

  assign rd_data        = mem[rd_ptr];
  assign bus.conv_left  = bus.conv_valid ? rd_data[2*W-1:W] : '0;
  assign bus.conv_right = bus.conv_valid ? rd_data[W-1:0]   : '0;

  // Pointers are AW bits wide, so they wrap modulo DEPTH on their own.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      fill          <= '0;
      overrun_count <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;

      case ({push_ok, pop})
        2'b10:   fill <= fill + 1'b1;
        2'b01:   fill <= fill - 1'b1;
        default: fill <= fill;
      endcase

      if (push_req && !push_ok && overrun_count != 8'hFF)
        overrun_count <= overrun_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_sample_scheduler.sv
// tb_sample_scheduler
//   Self-checking bench for sample_scheduler: a directed vector table,
//   hand-written corner sequences and a randomized run, all compared against
//   a queue-based reference model of the pairing and buffering rules.
module tb_sample_scheduler;

  localparam int DEPTH = 8;
  localparam int W     = 20;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic                   locked;
  logic [$clog2(DEPTH):0] fill;
  logic [7:0]             overrun_count;

  sample_scheduler_if #(.W(W)) bus ();

  sample_scheduler #(.DEPTH(DEPTH), .W(W)) dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus.slave),
    .locked        (locked),
    .fill          (fill),
    .overrun_count (overrun_count)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: lock flag, optional pending left sample, queue of pairs.
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic [W-1:0] l;
    logic [W-1:0] r;
  } pair_t;

  pair_t        mq[$];
  bit           m_locked;
  bit           m_have_left;
  logic [W-1:0] m_left;
  int           m_ovr;

  task automatic model_reset();
    mq.delete();
    m_locked    = 1'b0;
    m_have_left = 1'b0;
    m_left      = '0;
    m_ovr       = 0;
  endtask

  task automatic model_step(input logic vin, input logic ch, input logic [W-1:0] din,
                            input logic kill, input logic cv, input logic ready);
    bit    do_pop;
    bit    do_push;
    pair_t p;
    do_pop  = (mq.size() != 0) && ready;
    do_push = 1'b0;
    if (kill) begin
      m_locked    = 1'b0;
      m_have_left = 1'b0;
    end else if (!m_locked) begin
      if (cv) begin
        m_locked    = 1'b1;
        m_have_left = 1'b0;
      end
    end else if (vin) begin
      if (!ch) begin
        m_left      = din;
        m_have_left = 1'b1;
      end else if (m_have_left) begin
        p.l         = m_left;
        p.r         = din;
        do_push     = 1'b1;
        m_have_left = 1'b0;
      end
    end
    if (do_pop) void'(mq.pop_front());
    if (do_push) begin
      if (mq.size() < DEPTH) mq.push_back(p);
      else if (m_ovr < 255)  m_ovr++;
    end
  endtask

  task automatic compare_model();
    check("m_valid",  bus.conv_valid, (mq.size() != 0));
    check("m_locked", locked, m_locked);
    check("m_fill",   fill, mq.size());
    check("m_ovr",    overrun_count, m_ovr);
    if (mq.size() != 0) begin
      check("m_left",  bus.conv_left,  mq[0].l);
      check("m_right", bus.conv_right, mq[0].r);
    end
  endtask

  // One clock cycle: drive inputs, step the model, sample #1 after the edge.
  task automatic apply(input logic vin, input logic ch, input logic [W-1:0] din,
                       input logic kill, input logic cv, input logic ready);
    bus.vin         = vin;
    bus.in_channel  = ch;
    bus.din         = din;
    bus.kill        = kill;
    bus.channelvout = cv;
    bus.conv_ready  = ready;
    model_step(vin, ch, din, kill, cv, ready);
    @(posedge clk);
    #1;
    compare_model();
  endtask

  task automatic idle(input logic ready);
    apply(1'b0, 1'b0, '0, 1'b0, 1'b0, ready);
  endtask

  task automatic send_pair(input logic [W-1:0] l, input logic [W-1:0] r, input logic ready);
    apply(1'b1, 1'b0, l, 1'b0, 1'b0, ready);
    apply(1'b1, 1'b1, r, 1'b0, 1'b0, ready);
  endtask

  task automatic do_reset();
    bus.vin = 1'b0; bus.in_channel = 1'b0; bus.din = '0;
    bus.kill = 1'b0; bus.channelvout = 1'b0; bus.conv_ready = 1'b0;
    rst = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Directed vector table
  // ---------------------------------------------------------------------------
  typedef struct {
    logic         vin;
    logic         ch;
    logic [W-1:0] din;
    logic         kill;
    logic         cv;
    logic         ready;
    logic         ev;
    logic         el;
    int           ef;
    logic [W-1:0] eleft;
    logic [W-1:0] eright;
  } vec_t;

  function automatic vec_t mk(logic vin, logic ch, logic [W-1:0] din, logic kill,
                              logic cv, logic ready, logic ev, logic el, int ef,
                              logic [W-1:0] eleft, logic [W-1:0] eright);
    vec_t v;
    v.vin = vin; v.ch = ch; v.din = din; v.kill = kill; v.cv = cv; v.ready = ready;
    v.ev = ev; v.el = el; v.ef = ef; v.eleft = eleft; v.eright = eright;
    return v;
  endfunction

  vec_t vecs[8];

  initial begin
    bus.vin = 1'b0; bus.in_channel = 1'b0; bus.din = '0;
    bus.kill = 1'b0; bus.channelvout = 1'b0; bus.conv_ready = 1'b0;
    model_reset();

    //            vin ch din        kill cv rdy  ev el ef left     right
    vecs[0] = mk(1, 0, 20'h12345, 0, 0, 0,   0, 0, 0, '0,      '0);
    vecs[1] = mk(1, 1, 20'h54321, 0, 0, 0,   0, 0, 0, '0,      '0);
    vecs[2] = mk(0, 0, 20'h00000, 0, 1, 0,   0, 1, 0, '0,      '0);
    vecs[3] = mk(1, 0, 20'h00001, 0, 0, 1,   0, 1, 0, '0,      '0);
    vecs[4] = mk(1, 1, 20'h00002, 0, 0, 1,   1, 1, 1, 20'h1,   20'h2);
    vecs[5] = mk(0, 0, 20'h00000, 0, 0, 1,   0, 1, 0, '0,      '0);
    vecs[6] = mk(0, 0, 20'h00000, 1, 1, 1,   0, 0, 0, '0,      '0);
    vecs[7] = mk(0, 0, 20'h00000, 1, 1, 0,   0, 0, 0, '0,      '0);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid",  bus.conv_valid, 1'b0);
    check("rst_locked", locked, 1'b0);
    check("rst_fill",   fill, '0);
    check("rst_ovr",    overrun_count, '0);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      apply(vecs[i].vin, vecs[i].ch, vecs[i].din, vecs[i].kill, vecs[i].cv, vecs[i].ready);
      check($sformatf("tbl%0d_valid", i),  bus.conv_valid, vecs[i].ev);
      check($sformatf("tbl%0d_locked", i), locked, vecs[i].el);
      check($sformatf("tbl%0d_fill", i),   fill, vecs[i].ef);
      if (vecs[i].ev) begin
        check($sformatf("tbl%0d_left", i),  bus.conv_left,  vecs[i].eleft);
        check($sformatf("tbl%0d_right", i), bus.conv_right, vecs[i].eright);
      end
    end

    // Fill past capacity, then drain in order
    do_reset();
    apply(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0);
    for (int i = 1; i <= 10; i++) send_pair(W'(i), W'(32'h100 + i), 1'b0);
    check("full_fill", fill, DEPTH);
    check("full_ovr",  overrun_count, 2);
    for (int i = 1; i <= 8; i++) begin
      check($sformatf("drain%0d_left", i),  bus.conv_left,  W'(i));
      check($sformatf("drain%0d_right", i), bus.conv_right, W'(32'h100 + i));
      idle(1'b1);
    end
    check("drained_valid", bus.conv_valid, 1'b0);

    // Push and pop on the same edge while full
    for (int i = 1; i <= 8; i++) send_pair(W'(32'h200 + i), W'(32'h300 + i), 1'b0);
    apply(1'b1, 1'b0, 20'h77, 1'b0, 1'b0, 1'b0);
    apply(1'b1, 1'b1, 20'h88, 1'b0, 1'b0, 1'b1);
    check("pushpop_fill", fill, DEPTH);
    check("pushpop_ovr",  overrun_count, 2);
    check("pushpop_left", bus.conv_left, 20'h202);

    // Reset mid-stream, asynchronously between edges
    #2;
    rst = 1'b1;
    #1;
    check("arst_valid",  bus.conv_valid, 1'b0);
    check("arst_locked", locked, 1'b0);
    check("arst_fill",   fill, '0);
    check("arst_ovr",    overrun_count, '0);
    check("arst_left",   bus.conv_left, '0);
    check("arst_right",  bus.conv_right, '0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    // Samples after reset without a fresh lock strobe are ignored
    send_pair(20'h1111, 20'h2222, 1'b0);
    check("relock_needed_fill",   fill, '0);
    check("relock_needed_locked", locked, 1'b0);

    // Pair alignment: stray R, L=A, L=B, R=C -> one pair {B, C}
    do_reset();
    apply(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0);
    apply(1'b1, 1'b1, 20'h00011, 1'b0, 1'b0, 1'b0);
    apply(1'b1, 1'b0, 20'h0000A, 1'b0, 1'b0, 1'b0);
    apply(1'b1, 1'b0, 20'h0000B, 1'b0, 1'b0, 1'b0);
    apply(1'b1, 1'b1, 20'h0000C, 1'b0, 1'b0, 1'b0);
    check("align_fill",  fill, 1);
    check("align_left",  bus.conv_left,  20'h0000B);
    check("align_right", bus.conv_right, 20'h0000C);

    // Kill in the same cycle as the completing R sample
    apply(1'b1, 1'b0, 20'h0000D, 1'b0, 1'b0, 1'b0);
    apply(1'b1, 1'b1, 20'h0000E, 1'b1, 1'b0, 1'b0);
    check("kill_fill",   fill, 1);
    check("kill_locked", locked, 1'b0);
    check("kill_left",   bus.conv_left, 20'h0000B);
    send_pair(20'h5, 20'h6, 1'b0);
    check("unlocked_ignore_fill", fill, 1);
    apply(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0);
    check("relock_locked", locked, 1'b1);
    send_pair(20'h3, 20'h4, 1'b0);
    check("relock_fill", fill, 2);

    // Overrun counter saturation
    do_reset();
    apply(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 300; i++) send_pair(W'($urandom), W'($urandom), 1'b0);
    check("ovr_sat", overrun_count, 8'hFF);
    check("ovr_sat_fill", fill, DEPTH);

    // Randomized run with different downstream back-pressure levels
    do_reset();
    for (int seg = 0; seg < 4; seg++) begin
      for (int n = 0; n < 500; n++) begin
        logic r_ready;
        case (seg)
          0:       r_ready = ($urandom_range(0, 3) != 0);
          1:       r_ready = ($urandom_range(0, 7) == 0);
          2:       r_ready = 1'b1;
          default: r_ready = ($urandom_range(0, 1) != 0);
        endcase
        apply(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), W'($urandom),
              ($urandom_range(0, 63) == 0), ($urandom_range(0, 15) == 0), r_ready);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
